// File: rtl/beep_pattern_gen_if.sv
// Control handshake for the beep burst generator: start/beeps/stop requests in, busy/done status out.
// The master drives requests and observes status; the slave is the generator.
interface beep_pattern_gen_if;
    logic       start;
    logic [3:0] beeps;
    logic       stop;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output beeps,
        output stop,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  beeps,
        input  stop,
        output busy,
        output done
    );
endinterface

// File: rtl/beep_pattern_gen.sv
// Gates tone_in into a burst of N beeps with fixed on/off durations; BEEP_TONE_ALIGN_EN selects tone-aligned gating.
// busy rises one cycle after start; buzzer_out lags tone/gate by one cycle; start is ignored while busy, stop always wins.
module beep_pattern_gen #(
    parameter int unsigned ON_CYCLES  = 2700000,
    parameter int unsigned OFF_CYCLES = 2700000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    beep_pattern_gen_if.slave  ctrl,
    input  logic               tone_in,
    output logic               buzzer_out
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       remaining;
    logic [3:0]       remaining_nxt;
    logic             done_nxt;
    logic             busy_q;
    logic             done_q;
    logic             gate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            remaining <= remaining_nxt;
            busy_q    <= (state_nxt != S_IDLE);
            done_q    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        if (ctrl.stop) begin
            // Abort wins over everything, including a simultaneous start.
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            remaining_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl.start) begin
                        if (ctrl.beeps != 4'd0) begin
                            remaining_nxt = ctrl.beeps;
                            cnt_nxt       = ON_LOAD;
                            state_nxt     = S_ON;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (cnt == '0) begin
                        if (remaining == 4'd1) begin
                            remaining_nxt = '0;
                            state_nxt     = S_IDLE;
                            done_nxt      = 1'b1;
                        end else begin
                            remaining_nxt = remaining - 4'd1;
                            cnt_nxt       = OFF_LOAD;
                            state_nxt     = S_OFF;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (cnt == '0) begin
                        cnt_nxt   = ON_LOAD;
                        state_nxt = S_ON;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

`ifdef BEEP_TONE_ALIGN_EN
    // Gate only moves while the tone is low, so a high phase is either passed whole or not at all.
    logic gate_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q <= 1'b0;
        end else if (ctrl.stop) begin
            gate_q <= 1'b0;
        end else if (!tone_in) begin
            gate_q <= (state_nxt == S_ON);
        end
    end

    assign gate = gate_q;
`else
    assign gate = (state == S_ON);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzzer_out <= 1'b0;
        end else begin
            buzzer_out <= tone_in & gate;
        end
    end

    assign ctrl.busy = busy_q;
    assign ctrl.done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Randomized and directed bench for beep_pattern_gen with a schedule-based reference model.
module tb_beep_pattern_gen;
    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int PER = ON + OFF;

    logic clk = 1'b0;
    logic rst;
    logic tone_in;
    logic buzzer_out;

    beep_pattern_gen_if bus ();

    beep_pattern_gen #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (bus),
        .tone_in   (tone_in),
        .buzzer_out(buzzer_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: a burst is a schedule anchored at its first ON cycle.
    int   t = 0;
    logic m_busy, m_done, m_gate, m_buz, m_active;
    int   m_bstart, m_blen;

    always @(posedge clk) begin
        logic       i_start, i_stop, i_tone, new_buz, ongate;
        logic [3:0] i_beeps;
        t++;
        if (rst) begin
            m_busy = 0; m_done = 0; m_gate = 0; m_buz = 0; m_active = 0;
            m_bstart = 0; m_blen = 0;
        end else begin
            i_start = bus.start; i_beeps = bus.beeps; i_stop = bus.stop; i_tone = tone_in;
            new_buz = i_tone & m_gate;
            m_done = 0;
            if (i_stop) begin
                m_busy = 0; m_active = 0;
            end else if (!m_busy && i_start) begin
                if (i_beeps == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1; m_busy = 1; m_bstart = t;
                    m_blen = int'(i_beeps) * ON + (int'(i_beeps) - 1) * OFF;
                end
            end else if (m_active) begin
                if (t - m_bstart < m_blen) begin
                    m_busy = 1;
                end else begin
                    m_busy = 0; m_active = 0;
                    m_done = (t - m_bstart == m_blen);
                end
            end else begin
                m_busy = 0;
            end
            ongate = m_busy && (((t - m_bstart) % PER) < ON);
`ifdef BEEP_TONE_ALIGN_EN
            m_gate = i_stop ? 1'b0 : (i_tone ? m_gate : ongate);
`else
            m_gate = ongate;
`endif
            m_buz = new_buz;
            #1;
            if (!rst) begin
                chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
                chk("done", {31'd0, bus.done}, {31'd0, m_done});
                chk("buzzer", {31'd0, buzzer_out}, {31'd0, m_buz});
            end
        end
    end

    // Driver: one call per cycle, samples outputs at the falling edge then drives new inputs.
    int   tone_mode = 0;
    int   tone_ctr = 0;
    int   busy_cnt, done_cnt, buz_cnt;
    logic s_busy, s_done, s_buz;

    task automatic cyc(input logic s, input logic [3:0] b, input logic sp);
        logic [31:0] tc;
        @(negedge clk);
        s_busy = bus.busy; s_done = bus.done; s_buz = buzzer_out;
        if (s_busy) busy_cnt++;
        if (s_done) done_cnt++;
        if (s_buz)  buz_cnt++;
        tone_ctr++;
        tc = tone_ctr;
        case (tone_mode)
            0:       tone_in = tc[1];
            1:       tone_in = 1'($urandom % 2);
            default: tone_in = 1'b1;
        endcase
        bus.start = s; bus.beeps = b; bus.stop = sp;
    endtask

    task automatic clr_cnt();
        busy_cnt = 0; done_cnt = 0; buz_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; tone_in = 1'b0;
        bus.start = 1'b0; bus.beeps = 4'd0; bus.stop = 1'b0;
        #3;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_buzzer", {31'd0, buzzer_out}, 32'd0);
        repeat (2) cyc(0, 0, 0);
        rst = 1'b0;
        repeat (2) cyc(0, 0, 0);

        // Two-beep burst: 4 on, 3 off, 4 on.
        clr_cnt();
        cyc(1, 4'd2, 0);
        repeat (14) cyc(0, 0, 0);
        chk("burst2_busy_cycles", busy_cnt, 32'd11);
        chk("burst2_done_pulses", done_cnt, 32'd1);

        // Empty burst.
        clr_cnt();
        cyc(1, 4'd0, 0);
        cyc(0, 0, 0);
        chk("empty_done_next", {31'd0, s_done}, 32'd1);
        repeat (4) cyc(0, 0, 0);
        chk("empty_busy_cycles", busy_cnt, 32'd0);
        chk("empty_buz_cycles", buz_cnt, 32'd0);
        chk("empty_done_pulses", done_cnt, 32'd1);

        // stop with start in the same cycle: nothing starts.
        clr_cnt();
        cyc(1, 4'd3, 1);
        repeat (4) cyc(0, 0, 0);
        chk("stop_start_busy", busy_cnt, 32'd0);

        // Stop in the second OFF cycle of a 3-beep burst.
        clr_cnt();
        cyc(1, 4'd3, 0);
        repeat (5) cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("stop_off_busy_next", {31'd0, s_busy}, 32'd0);
        cyc(0, 0, 0);
        chk("stop_off_buz", {31'd0, s_buz}, 32'd0);
        repeat (4) cyc(0, 0, 0);
        chk("stop_off_no_done", done_cnt, 32'd0);
        clr_cnt();
        cyc(1, 4'd1, 0);
        repeat (6) cyc(0, 0, 0);
        chk("restart_busy", busy_cnt, 32'd4);
        chk("restart_done", done_cnt, 32'd1);

        // Stop mid-ON with tone held high: buzzer drops one cycle after busy.
        tone_mode = 2;
        cyc(1, 4'd2, 0);
        repeat (2) cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("stop_on_busy", {31'd0, s_busy}, 32'd0);
        chk("stop_on_buz_lag", {31'd0, s_buz}, 32'd1);
        cyc(0, 0, 0);
        chk("stop_on_buz_off", {31'd0, s_buz}, 32'd0);
        tone_mode = 0;

        // Starts while busy are ignored; start in the done cycle chains a new burst.
        clr_cnt();
        cyc(1, 4'd2, 0);
        for (int i = 1; i <= 11; i++) cyc((i % 3) == 0, 4'd15, 0);
        cyc(1, 4'd1, 0);
        chk("chain_done_cycle", {31'd0, s_done}, 32'd1);
        repeat (7) cyc(0, 0, 0);
        chk("chain_busy_cycles", busy_cnt, 32'd15);
        chk("chain_done_pulses", done_cnt, 32'd2);

        // Random traffic against the model.
        tone_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom % 100);
            if (r < 8)        cyc(1, 4'($urandom % 4), 0);
            else if (r == 8)  cyc(1, 4'($urandom % 16), 0);
            else if (r < 11)  cyc(0, 0, 1);
            else if (r == 11) cyc(1, 4'd2, 1);
            else              cyc(0, 0, 0);
        end

        // Asynchronous reset between clock edges during ON.
        tone_mode = 2;
        repeat (PER * 16) cyc(0, 0, 1);
        cyc(1, 4'd2, 0);
        repeat (3) cyc(0, 0, 0);
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("pre_rst_buz", {31'd0, buzzer_out}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_buz", {31'd0, buzzer_out}, 32'd0);
        chk("async_rst_done", {31'd0, bus.done}, 32'd0);
        cyc(0, 0, 0);
        rst = 1'b0;
        tone_mode = 0;
        clr_cnt();
        cyc(1, 4'd1, 0);
        repeat (6) cyc(0, 0, 0);
        chk("post_rst_done", done_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/beep_pattern_gen.md
# beep_pattern_gen

Downstream consumer of the 400 Hz square-wave tone generator. Gates the free-running `tone_in` square wave into a programmable burst of N beeps with fixed on/off durations, and drives the buzzer pin. Software/control logic triggers a burst with a single-cycle `start` and observes `busy`/`done`.

## Interface
Parameters:
- `ON_CYCLES`, 2700000, length of each beep in `clk` cycles (100 ms at 27 MHz); must be ≥ 1
- `OFF_CYCLES`, 2700000, silent gap between beeps in `clk` cycles; must be ≥ 1
- `CNT_W`, 32, width of the duration down-counter; must hold max(ON_CYCLES, OFF_CYCLES) − 1

Ports:
- `clk`  in  1  system clock (27 MHz)
- `rst`  in  1  asynchronous reset, active-high; one clock domain, `clk` only
- `start`  in  1  request a burst; sampled on rising `clk`
- `beeps`  in  4  beep count for the burst, sampled with `start`; 0 = empty burst
- `stop`  in  1  abort the current burst
- `tone_in`  in  1  square wave from the tone generator, synchronous to `clk`
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse on normal burst completion
- `buzzer_out`  out  1  gated tone to the buzzer pin

## Operation
- Reset values: state IDLE, counter 0, remaining 0, `busy`=0, `done`=0, `buzzer_out`=0, gate=0.
- States: IDLE, ON, OFF. `busy` = (state != IDLE), registered with the state.
- IDLE, `start`=1, `beeps`≠0: latch `beeps` into `remaining`, load counter with ON_CYCLES−1, go to ON.
- IDLE, `start`=1, `beeps`=0: stay in IDLE; `done` pulses the next cycle.
- ON: counter decrements each cycle. At counter=0: if `remaining`=1 → IDLE and pulse `done`; else decrement `remaining`, load OFF_CYCLES−1, go to OFF.
- OFF: counter decrements. At 0: load ON_CYCLES−1, go to ON.
- `start` while busy: ignored; `beeps` is not re-sampled.
- `stop`=1 in any state: next state IDLE, gate cleared, no `done`. `stop` and `start` asserted in the same cycle: `stop` wins and nothing starts.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously).
- Gate: without the macro, gate = (state == ON).
- `buzzer_out` is registered: `buzzer_out`(t+1) = `tone_in`(t) & gate(t).

## Timing
- `start` sampled at edge k → `busy`=1 from k+1; the first ON cycle is k+1.
- Each beep spans exactly ON_CYCLES cycles in ON; each gap spans exactly OFF_CYCLES cycles in OFF; there is no gap after the last beep.
- `busy` is high for N·ON_CYCLES + (N−1)·OFF_CYCLES cycles.
- `done` is high for exactly one cycle: the first cycle with `busy`=0 after the final ON cycle.
- For an empty burst, `done` is high at k+1 and `busy` never rises.
- `buzzer_out` lags `tone_in` and the gate by 1 cycle.
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back bursts.
- `stop` at edge k: `busy`=0 from k+1, `buzzer_out`=0 from k+2.

## Configuration
- `BEEP_TONE_ALIGN_EN` defined: glitch-free gating. The gate register follows (state == ON) only in cycles where `tone_in`=0; while `tone_in`=1 it holds its value. No truncated high pulses reach the buzzer. State and `busy`/`done` timing are unchanged. `stop` and `rst` still clear the gate immediately.
- Not defined: gate = (state == ON) combinationally; edges of `buzzer_out` may truncate a tone high phase.

## Test plan
Test parameters: ON_CYCLES=4, OFF_CYCLES=3; `tone_in` toggles every 2 cycles unless stated.
- Reset, then `start` with `beeps`=2 → `busy` high 11 cycles; gate high 4, low 3, high 4; `done` pulses once, in the cycle `busy` falls.
- `start` with `beeps`=0 → `done`=1 the next cycle; `busy` and `buzzer_out` stay 0.
- `stop` pulse in the 2nd cycle of the first OFF (`beeps`=3) → `busy`=0 the next cycle, `buzzer_out`=0 one cycle after that, no `done`; a new `start` is then accepted normally.
- `start` pulses during busy with `beeps`=15 → ignored; the burst completes with the original count. `start`+`beeps`=1 in the `done` cycle → a new 4-cycle burst begins immediately.
- `rst` asserted mid-ON between clock edges → `busy`, `buzzer_out` and `done` go 0 without waiting for `clk`.
- With `BEEP_TONE_ALIGN_EN`, `tone_in` high for 3 cycles around the ON entry/exit → the first `buzzer_out` high pulse is a full tone high phase; no 1-cycle slivers.
